// File: rtl/demux1to4_16b_reg.sv
// Registered 1-to-4 demultiplexer: one input word is steered into one of four lane holding registers.
// Each lane has its own valid/ready handshake. Defining DEMUX_LANE_CNT_EN adds 8-bit fill counters per lane.
module demux1to4_16b_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clkpos,
   input  logic             rst,
   input  logic             vdd,
   input  logic             vss,
   input  logic [WIDTH-1:0] din,
   input  logic             in0,
   input  logic             in1,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic             a_valid,
   output logic             b_valid,
   output logic             c_valid,
   output logic             d_valid,
   input  logic             a_ready,
   input  logic             b_ready,
   input  logic             c_ready,
   input  logic             d_ready
`ifdef DEMUX_LANE_CNT_EN
   ,
   output logic [7:0]       a_cnt,
   output logic [7:0]       b_cnt,
   output logic [7:0]       c_cnt,
   output logic [7:0]       d_cnt
`endif
);

   logic [WIDTH-1:0] r_data [4];
   logic [3:0]       r_valid;
   logic [1:0]       w_sel;
   logic [3:0]       w_ready;
   logic [3:0]       w_fill;
   logic [3:0]       w_drain;
   logic             w_din_ready;
   logic             w_unused_supply;

   // Supply pins are carried only for netlist compatibility.
   assign w_unused_supply = vdd ^ vss;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_fill      = '0;
      w_sel       = {in1, in0};
      w_ready     = {d_ready, c_ready, b_ready, a_ready};
      w_drain     = r_valid & w_ready;
      w_din_ready = ~r_valid[w_sel] | w_ready[w_sel];
      for (int i = 0; i < 4; i++) begin
         w_fill[i] = din_valid & w_din_ready & (w_sel == 2'(i));
      end
   end

   always_ff @(posedge clkpos) begin
      // NOTE: sequential state uses non-blocking assignments so all lanes update from pre-edge values.
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < 4; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_fill[i]) begin
               r_data[i]  <= din;
               r_valid[i] <= 1'b1;
            end else if (w_drain[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
      end
   end

`ifdef DEMUX_LANE_CNT_EN
   logic [7:0] r_cnt [4];

   // Counters wrap naturally at 8 bits; drains never touch them.
   always_ff @(posedge clkpos) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_fill[i]) begin
               r_cnt[i] <= r_cnt[i] + 8'd1;
            end
         end
      end
   end

   assign a_cnt = r_cnt[0];
   assign b_cnt = r_cnt[1];
   assign c_cnt = r_cnt[2];
   assign d_cnt = r_cnt[3];
`endif

   assign din_ready = w_din_ready;
   assign a         = r_data[0];
   assign b         = r_data[1];
   assign c         = r_data[2];
   assign d         = r_data[3];
   assign a_valid   = r_valid[0];
   assign b_valid   = r_valid[1];
   assign c_valid   = r_valid[2];
   assign d_valid   = r_valid[3];

endmodule

// File: tb/tb_demux1to4_16b_reg.sv
// Self-checking bench for demux1to4_16b_reg: directed scenarios plus random traffic against a slot model.
// Counter checks are compiled when DEMUX_LANE_CNT_EN is defined.
module tb_demux1to4_16b_reg;

   logic        clkpos = 1'b0;
   logic        rst = 1'b0;
   logic        vdd = 1'b1;
   logic        vss = 1'b0;
   logic [15:0] din = '0;
   logic        in0 = 1'b0;
   logic        in1 = 1'b0;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic [15:0] a, b, c, d;
   logic        a_valid, b_valid, c_valid, d_valid;
   logic        a_ready = 1'b0;
   logic        b_ready = 1'b0;
   logic        c_ready = 1'b0;
   logic        d_ready = 1'b0;
`ifdef DEMUX_LANE_CNT_EN
   logic [7:0]  a_cnt, b_cnt, c_cnt, d_cnt;
`endif

   demux1to4_16b_reg #(.WIDTH(16)) dut (
      .clkpos(clkpos), .rst(rst), .vdd(vdd), .vss(vss),
      .din(din), .in0(in0), .in1(in1), .din_valid(din_valid), .din_ready(din_ready),
      .a(a), .b(b), .c(c), .d(d),
      .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
      .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready)
`ifdef DEMUX_LANE_CNT_EN
      , .a_cnt(a_cnt), .b_cnt(b_cnt), .c_cnt(c_cnt), .d_cnt(d_cnt)
`endif
   );

   always #5 clkpos = ~clkpos;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: each lane is a one-word slot (-1 = empty) plus the last word it displayed.
   int          m_held  [4];
   logic [15:0] m_shown [4];
   int          m_cnt   [4];
   bit          m_known = 1'b0;

   logic [15:0] obs_data  [4];
   logic        obs_valid [4];
   logic [7:0]  obs_cnt   [4];

   always_comb begin
      obs_data[0] = a;  obs_data[1] = b;  obs_data[2] = c;  obs_data[3] = d;
      obs_valid[0] = a_valid; obs_valid[1] = b_valid; obs_valid[2] = c_valid; obs_valid[3] = d_valid;
`ifdef DEMUX_LANE_CNT_EN
      obs_cnt[0] = a_cnt; obs_cnt[1] = b_cnt; obs_cnt[2] = c_cnt; obs_cnt[3] = d_cnt;
`else
      for (int i = 0; i < 4; i++) obs_cnt[i] = '0;
`endif
   end

   task automatic compare_lanes();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("lane%0d_data", i), 32'(obs_data[i]), 32'(m_shown[i]));
         check($sformatf("lane%0d_valid", i), 32'(obs_valid[i]), 32'(m_held[i] >= 0));
`ifdef DEMUX_LANE_CNT_EN
         check($sformatf("lane%0d_cnt", i), 32'(obs_cnt[i]), 32'(m_cnt[i]));
`endif
      end
   endtask

   // One clock: drive after the falling edge, check pre-edge outputs, advance the model, return after the rising edge.
   task automatic step(input bit r, input bit v, input int sel, input logic [15:0] data, input logic [3:0] rdy);
      bit accept;
      @(negedge clkpos);
      rst = r;
      din_valid = v;
      {in1, in0} = sel[1:0];
      din = data;
      {d_ready, c_ready, b_ready, a_ready} = rdy;
      #1;
      if (m_known) begin
         compare_lanes();
         check("din_ready", 32'(din_ready), 32'((m_held[sel] < 0) || rdy[sel]));
      end
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            m_held[i] = -1;
            m_shown[i] = '0;
            m_cnt[i] = 0;
         end
         m_known = 1'b1;
      end else begin
         accept = v && ((m_held[sel] < 0) || rdy[sel]);
         for (int i = 0; i < 4; i++) begin
            if (m_held[i] >= 0 && rdy[i]) m_held[i] = -1;
         end
         if (accept) begin
            m_held[sel] = int'(data);
            m_shown[sel] = data;
            m_cnt[sel] = (m_cnt[sel] + 1) % 256;
         end
      end
      @(posedge clkpos);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         m_held[i] = -1;
         m_shown[i] = '0;
         m_cnt[i] = 0;
      end

      // Reset then idle.
      step(1, 0, 0, 16'h0, 4'h0);
      step(1, 0, 0, 16'h0, 4'h0);
      #1;
      check("rst_a", 32'(a), 32'h0);
      check("rst_d", 32'(d), 32'h0);
      check("rst_valids", 32'({a_valid, b_valid, c_valid, d_valid}), 32'h0);
      for (int s = 0; s < 4; s++) step(0, 0, s, 16'h0, 4'h0);

      // Single route to lane c, held until c_ready.
      step(0, 1, 2, 16'hA5A5, 4'h0);
      #1;
      check("route_c_data", 32'(c), 32'hA5A5);
      check("route_c_valid", 32'(c_valid), 32'h1);
      check("route_abd_valid", 32'({a_valid, b_valid, d_valid}), 32'h0);
      step(0, 0, 0, 16'h0, 4'h0);
      #1;
      check("route_c_hold", 32'(c_valid), 32'h1);
      step(0, 0, 0, 16'h0, 4'b0100);
      #1;
      check("route_c_drained", 32'(c_valid), 32'h0);
      check("route_c_data_kept", 32'(c), 32'hA5A5);

      // Backpressure on lane b, then pass-through fill.
      step(0, 1, 1, 16'h0001, 4'h0);
      @(negedge clkpos);
      din_valid = 1'b1; {in1, in0} = 2'b01; din = 16'h0002;
      #1;
      check("bp_din_ready", 32'(din_ready), 32'h0);
      step(0, 1, 1, 16'h0002, 4'h0);
      #1;
      check("bp_b_held", 32'(b), 32'h0001);
      step(0, 1, 1, 16'h0002, 4'b0010);
      #1;
      check("bp_b_passthru", 32'(b), 32'h0002);
      check("bp_b_valid", 32'(b_valid), 32'h1);
      step(0, 0, 0, 16'h0, 4'b0010);

      // Round-robin streaming with all readies high.
      for (int i = 0; i < 4; i++) begin
         step(0, 1, i, 16'(i + 1), 4'hF);
         #1;
         check($sformatf("rr_lane%0d_data", i), 32'(obs_data[i]), 32'(i + 1));
         check($sformatf("rr_valid_onehot%0d", i),
               32'({d_valid, c_valid, b_valid, a_valid}), 32'(1 << i));
      end
      step(0, 0, 0, 16'h0, 4'hF);

      // Reset mid-operation discards held words and blocks the fill.
      step(0, 1, 0, 16'hFFFF, 4'h0);
      step(0, 1, 3, 16'h1234, 4'h0);
      step(1, 1, 0, 16'h5555, 4'h0);
      #1;
      check("midrst_valids", 32'({a_valid, b_valid, c_valid, d_valid}), 32'h0);
      check("midrst_a", 32'(a), 32'h0);
      check("midrst_d", 32'(d), 32'h0);
      step(0, 0, 0, 16'h0, 4'h0);

`ifdef DEMUX_LANE_CNT_EN
      // 257 fills to lane d wrap its counter to 1.
      for (int i = 0; i < 257; i++) step(0, 1, 3, 16'($urandom), 4'b1000);
      #1;
      check("cnt_d_wrap", 32'(d_cnt), 32'h1);
      check("cnt_abc_zero", 32'({a_cnt, b_cnt, c_cnt}), 32'h0);
      step(1, 0, 0, 16'h0, 4'h0);
      #1;
      check("cnt_d_reset", 32'(d_cnt), 32'h0);
`endif

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
              16'($urandom), 4'($urandom));
      end
      @(negedge clkpos);
      #1;
      compare_lanes();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
